// File: rtl/pilha_ctrl.sv
// pilha_ctrl: stack instruction sequencer for the Pilha/temp/ULA datapath.
// Accepts PUSHI, POP and ALU instructions over valid/ready and issues the
// per-cycle pop/loadTemp1/loadTemp2/push/opcode strobes plus din.
// Ports: clk, reset (async, active high); instr_valid/instr_ready/instr_op/
// instr_imm handshake; push, pop, loadTemp1, loadTemp2, opcode, din to the
// datapath; resultado from the ULA; result, done, err, depth status.
// Optional macro PILHA_CTRL_GUARD_EN enables the depth guard at accept.
module pilha_ctrl #(
   parameter int STACK_DEPTH = 16,
   localparam int DW = $clog2(STACK_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [3:0]    instr_op,
   input  logic [15:0]   instr_imm,
   output logic          push,
   output logic          pop,
   output logic          loadTemp1,
   output logic          loadTemp2,
   output logic [2:0]    opcode,
   output logic [15:0]   din,
   input  logic [31:0]   resultado,
   output logic [31:0]   result,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] depth
);

   typedef enum logic [2:0] {
      IDLE,
      PUSH,
      POPD,
      POP1,
      POP2,
      EXEC,
      WB,
      ERR
   } state_t;

   state_t        state_q, state_d;
   logic [15:0]   imm_q, imm_d;
   logic [2:0]    opcode_q, opcode_d;
   logic [31:0]   result_q, result_d;
   logic [DW-1:0] depth_q, depth_d;

   logic is_pushi, is_pop, is_alu;
   logic ok_push, ok_pop, ok_alu;

   assign is_pushi = (instr_op == 4'd0);
   assign is_pop   = (instr_op == 4'd1);
   assign is_alu   = instr_op[3];

`ifdef PILHA_CTRL_GUARD_EN
   assign ok_push = (depth_q < DW'(STACK_DEPTH));
   assign ok_pop  = (depth_q >= DW'(1));
   assign ok_alu  = (depth_q >= DW'(2));
`else
   assign ok_push = 1'b1;
   assign ok_pop  = 1'b1;
   assign ok_alu  = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         imm_q    <= '0;
         opcode_q <= '0;
         result_q <= '0;
         depth_q  <= '0;
      end else begin
         state_q  <= state_d;
         imm_q    <= imm_d;
         opcode_q <= opcode_d;
         result_q <= result_d;
         depth_q  <= depth_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      imm_d       = imm_q;
      opcode_d    = opcode_q;
      result_d    = result_q;
      instr_ready = 1'b0;
      push        = 1'b0;
      pop         = 1'b0;
      loadTemp1   = 1'b0;
      loadTemp2   = 1'b0;
      din         = '0;
      done        = 1'b0;
      err         = 1'b0;

      unique case (state_q)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               imm_d = instr_imm;
               unique case (1'b1)
                  is_pushi && ok_push: state_d = PUSH;
                  is_pop && ok_pop:    state_d = POPD;
                  is_alu && ok_alu: begin
                     state_d  = POP1;
                     opcode_d = instr_op[2:0];
                  end
                  default:             state_d = ERR;
               endcase
            end
         end
         PUSH: begin
            push    = 1'b1;
            din     = imm_q;
            done    = 1'b1;
            state_d = IDLE;
         end
         POPD: begin
            pop     = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         // temp1 samples the top before the pop takes effect
         POP1: begin
            pop       = 1'b1;
            loadTemp1 = 1'b1;
            state_d   = POP2;
         end
         POP2: begin
            pop       = 1'b1;
            loadTemp2 = 1'b1;
            state_d   = EXEC;
         end
         EXEC: begin
            result_d = resultado;
            state_d  = WB;
         end
         WB: begin
            push    = 1'b1;
            din     = result_q[15:0];
            done    = 1'b1;
            state_d = IDLE;
         end
         ERR: begin
            err     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      depth_d = depth_q + DW'(push) - DW'(pop);
   end

   assign opcode = opcode_q;
   assign result = result_q;
   assign depth  = depth_q;

endmodule

// File: tb/tb_pilha_ctrl.sv
// tb_pilha_ctrl: directed bench for pilha_ctrl with a small behavioural
// Pilha/temp/ULA around it (ULA: 0 add, 1 t1-t2, other t1*t2).
module tb_pilha_ctrl;

   localparam int SD = 16;
   localparam int DW = $clog2(SD + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          instr_valid;
   logic          instr_ready;
   logic [3:0]    instr_op;
   logic [15:0]   instr_imm;
   logic          push, pop, loadTemp1, loadTemp2;
   logic [2:0]    opcode;
   logic [15:0]   din;
   logic [31:0]   resultado;
   logic [31:0]   result;
   logic          done, err;
   logic [DW-1:0] depth;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pilha_ctrl #(.STACK_DEPTH(SD)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_imm(instr_imm),
      .push(push), .pop(pop),
      .loadTemp1(loadTemp1), .loadTemp2(loadTemp2),
      .opcode(opcode), .din(din),
      .resultado(resultado), .result(result),
      .done(done), .err(err), .depth(depth)
   );

   // datapath environment
   logic [15:0] stk [32];
   logic [4:0]  sp;
   logic [15:0] t1, t2;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         sp <= '0;
         t1 <= '0;
         t2 <= '0;
      end else begin
         if (loadTemp1) t1 <= stk[sp - 5'd1];
         if (loadTemp2) t2 <= stk[sp - 5'd1];
         if (pop)       sp <= sp - 5'd1;
         if (push)      sp <= sp + 5'd1;
      end
   end

   always @(posedge clk) begin
      if (!reset && push) stk[sp] <= din;
   end

   always_comb begin
      resultado = '0;
      case (opcode)
         3'd0:    resultado = {16'd0, t1} + {16'd0, t2};
         3'd1:    resultado = {16'd0, t1} - {16'd0, t2};
         default: resultado = {16'd0, t1} * {16'd0, t2};
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [15:0] imm);
      @(negedge clk);
      chk("ready_pre", instr_ready, 1);
      instr_op    = op;
      instr_imm   = imm;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
   endtask

   task automatic pushi(input logic [15:0] imm);
      issue(4'd0, imm);
      @(negedge clk);
      chk("pushi_push", push, 1);
      chk("pushi_din", din, {16'd0, imm});
      chk("pushi_done", done, 1);
      chk("pushi_busy", instr_ready, 0);
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] exp);
      issue(op, 16'd0);
      @(negedge clk);
      chk("a1_pop", pop, 1);
      chk("a1_lt1", loadTemp1, 1);
      chk("a1_lt2", loadTemp2, 0);
      chk("a1_push", push, 0);
      @(negedge clk);
      chk("a2_pop", pop, 1);
      chk("a2_lt2", loadTemp2, 1);
      chk("a2_lt1", loadTemp1, 0);
      @(negedge clk);
      chk("a3_idle", {push, pop, loadTemp1, loadTemp2, done}, 0);
      chk("a3_din", din, 0);
      @(negedge clk);
      chk("a4_push", push, 1);
      chk("a4_din", din, {16'd0, exp[15:0]});
      chk("a4_done", done, 1);
      chk("a4_result", result, exp);
      chk("a4_opcode", opcode, {29'd0, op[2:0]});
   endtask

   initial begin
      reset       = 1'b1;
      instr_valid = 1'b0;
      instr_op    = '0;
      instr_imm   = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_ready", instr_ready, 1);
      chk("rst_depth", depth, 0);
      chk("rst_strobes", {push, pop, loadTemp1, loadTemp2}, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_result", result, 0);
      chk("rst_din", din, 0);
      chk("rst_opcode", opcode, 0);

      pushi(16'h0005);
      pushi(16'h0003);
      @(negedge clk);
      chk("depth_2", depth, 2);

      // add with instr_valid held: no second accept until cycle 5
      instr_op    = 4'd8;
      instr_imm   = '0;
      instr_valid = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("h1_ready", instr_ready, 0);
      chk("h1_pop_lt1", {pop, loadTemp1, loadTemp2}, 3'b110);
      @(negedge clk);
      chk("h2_ready", instr_ready, 0);
      chk("h2_pop_lt2", {pop, loadTemp1, loadTemp2}, 3'b101);
      @(negedge clk);
      chk("h3_ready", instr_ready, 0);
      chk("h3_quiet", {push, pop, done}, 0);
      @(negedge clk);
      chk("h4_ready", instr_ready, 0);
      chk("h4_push_done", {push, done}, 2'b11);
      chk("h4_din", din, 32'h0008);
      chk("h4_result", result, 32'h0000_0008);
      @(negedge clk);
      chk("h5_ready", instr_ready, 1);
      chk("h5_depth", depth, 1);
      instr_valid = 1'b0;

      pushi(16'h000A);
      alu(4'd9, 32'h0000_0002);
      pushi(16'hFFFF);
      alu(4'd10, 32'h0001_FFFE);
      @(negedge clk);
      chk("mul_depth", depth, 1);

      issue(4'd3, 16'h1234);
      @(negedge clk);
      chk("ill_err", err, 1);
      chk("ill_done", done, 0);
      chk("ill_strobes", {push, pop, loadTemp1, loadTemp2}, 0);
      @(negedge clk);
      chk("ill_err_off", err, 0);
      chk("ill_ready", instr_ready, 1);
      chk("ill_depth", depth, 1);
      chk("ill_opcode", opcode, 2);

`ifdef PILHA_CTRL_GUARD_EN
      issue(4'd8, 16'd0);
      @(negedge clk);
      chk("g_alu_err", err, 1);
      chk("g_alu_strobes", {push, pop, loadTemp1, loadTemp2, done}, 0);
      @(negedge clk);
      chk("g_alu_depth", depth, 1);
      for (int i = 0; i < SD - 1; i++) pushi(16'(i + 100));
      @(negedge clk);
      chk("g_full_depth", depth, SD);
      issue(4'd0, 16'h0BAD);
      @(negedge clk);
      chk("g_ovf_err", err, 1);
      chk("g_ovf_push", {push, done}, 0);
      @(negedge clk);
      chk("g_ovf_depth", depth, SD);
`else
      issue(4'd1, 16'd0);
      @(negedge clk);
      chk("ng_pop", {pop, done, err}, 3'b110);
      issue(4'd1, 16'd0);
      @(negedge clk);
      chk("ng_pop0", {pop, done, err}, 3'b110);
      @(negedge clk);
      chk("ng_wrap", depth, 31);
`endif

      // reset during POP2
      issue(4'd8, 16'd0);
      @(negedge clk);
      chk("r1_pop", pop, 1);
      @(negedge clk);
      chk("r2_lt2", {pop, loadTemp2}, 2'b11);
      reset = 1'b1;
      #1;
      chk("r_strobes", {push, pop, loadTemp1, loadTemp2, done, err}, 0);
      chk("r_depth", depth, 0);
      chk("r_ready", instr_ready, 1);
      chk("r_result", result, 0);
      @(negedge clk);
      reset = 1'b0;
      pushi(16'h0007);
      @(negedge clk);
      chk("r_push_depth", depth, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pilha_ctrl.md
# pilha_ctrl

Instruction sequencer for the stack datapath (Pilha, two temp registers, ULA). It accepts one stack instruction at a time over a valid/ready handshake. It then issues the cycle-ordered pop, loadTemp1, loadTemp2, push and opcode strobes that execute the instruction. It drives the datapath `din` itself, selecting either the immediate or the ULA write-back, and tracks stack depth for overflow/underflow guarding.

## Interface
- `STACK_DEPTH`, 16: number of Pilha entries. The depth counter width is $clog2(STACK_DEPTH+1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  instruction presented.
- `instr_ready`  out  1  controller idle, can accept; reset 1.
- `instr_op`  in  4  0 = PUSHI, 1 = POP, 8–15 = ALU op with ULA opcode `instr_op[2:0]`, 2–7 illegal.
- `instr_imm`  in  16  immediate for PUSHI.
- `push`  out  1  Pilha push strobe; reset 0.
- `pop`  out  1  Pilha pop strobe; reset 0.
- `loadTemp1`  out  1  temp1 load strobe; reset 0.
- `loadTemp2`  out  1  temp2 load strobe; reset 0.
- `opcode`  out  3  ULA opcode, registered; reset 0.
- `din`  out  16  Pilha write data; reset 0.
- `resultado`  in  32  ULA output (combinational from temps).
- `result`  out  32  registered full ULA result of the last ALU op; reset 0.
- `done`  out  1  one-cycle pulse, instruction completed; reset 0.
- `err`  out  1  one-cycle pulse, instruction rejected; reset 0.
- `depth`  out  $clog2(STACK_DEPTH+1)  current stack occupancy; reset 0.

## Operation
- States: IDLE, PUSH, POPD, POP1, POP2, EXEC, WB, ERR. Reset enters IDLE.
- IDLE: `instr_ready`=1. Accept occurs on a rising edge with `instr_valid & instr_ready`, which latches op and imm.
- Transitions on accept:
  - PUSHI goes to PUSH.
  - POP goes to POPD.
  - ALU goes to POP1 and `opcode` <= op[2:0].
  - Illegal op or failed guard goes to ERR.
- PUSH: `push`=1, `din`=imm, `done`=1, then IDLE.
- POPD: `pop`=1, `done`=1, then IDLE. The popped value is discarded.
- POP1: `pop`=1 and `loadTemp1`=1 in the same cycle. temp1 captures the current top, so operando1 is the old top. Then POP2.
- POP2: `pop`=1 and `loadTemp2`=1, so operando2 is the second entry. Then EXEC.
- EXEC: no strobes; `result` <= `resultado` at the end of the cycle. Then WB.
- WB: `push`=1, `din`=`result[15:0]`, `done`=1, then IDLE. `result[31:16]` is available only on `result`.
- ERR: `err`=1, no datapath strobes, then IDLE.
- `opcode` holds its value from POP1 through WB and until the next ALU accept.
- `din` is 0 in every state other than PUSH and WB.
- Depth counter changes:
  - +1 on each cycle with `push`.
  - −1 on each cycle with `pop`.
  - Net effect of an ALU op is −1.
- Illegal ops (2–7) always go to ERR, regardless of configuration.

## Timing
- Accept at edge 0 sets the following latencies:
  - PUSHI/POP: strobe and `done` in cycle 1; `instr_ready` is 1 again in cycle 2.
  - ALU: POP1 in cycle 1, POP2 in cycle 2, EXEC in cycle 3, WB with `done` in cycle 4. `instr_ready` returns in cycle 5, and `result` is valid from cycle 4.
- Throughput:
  - PUSHI/POP: one instruction per 2 cycles.
  - ALU: one instruction per 5 cycles.
- At most one strobe pair is active per cycle; `push` and `pop` are never asserted together.
- `instr_valid` while not ready is ignored. The source holds op and imm until accepted.
- Asserting `reset` mid-instruction immediately zeroes all outputs, clears `depth` and forces IDLE. The Pilha and temps share `reset`, so the partial instruction is simply lost.

## Configuration
- `PILHA_CTRL_GUARD_EN` defined: the depth guard is checked at accept. A failing instruction goes to ERR. Pass conditions:
  - PUSHI requires `depth` < STACK_DEPTH.
  - POP requires `depth` ≥ 1.
  - ALU requires `depth` ≥ 2.
- `PILHA_CTRL_GUARD_EN` undefined: no guard. Every legal op executes, and `depth` wraps modulo 2^width. `err` then fires only for illegal ops.

## Test plan
- Reset, then check outputs. Required: `instr_ready`=1, `depth`=0, all strobes, `done`, `err` and `result` = 0.
- PUSHI 0x0005 then PUSHI 0x0003. Required: `push`=1 with `din`=0x0005, then 0x0003, each with `done` in cycle 1; `depth`=2.
- ALU op 8 (ULA opcode 000, add) on stack [0x0003 top, 0x0005]. Required:
  - `pop`+`loadTemp1` in cycle 1 and `pop`+`loadTemp2` in cycle 2.
  - `result`=0x00000008 in cycle 4, with `push`, `din`=0x0008 and `done` in cycle 4.
  - `depth`=1 afterwards.
- With GUARD_EN: ALU at depth 1 gives `err` in cycle 1, no strobes, `depth` unchanged. STACK_DEPTH PUSHIs followed by one more PUSHI gives `err` on the last.
- Illegal op 3 gives `err` pulse and no `done` with either configuration. Holding `instr_valid` during an ALU op gives no second accept until cycle 5.
- Assert `reset` during POP2. Required: strobes drop asynchronously, `depth`=0, state IDLE, and a following PUSHI executes normally.
